// File: rtl/sram_sync_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sram_sync_param
//   Single-clock, one-write/one-read synchronous SRAM with byte enables.
//   After reset the array is cleared one word per clock (INIT). While the
//   clear runs, all requests are ignored. Once every word holds zero the
//   block enters RUN and serves requests.
//
//   Reads have a latency of one cycle. A write and a read to the same word
//   on the same edge return the newly merged word (write-first).
//   Addresses at or above DEPTH are rejected and never aliased. A rejected
//   write is dropped. A rejected read returns zero. Either case produces a
//   one-cycle addr_err pulse.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   write request
//   wr_addr    in   [ADDR_WIDTH-1:0] write word address
//   wr_data    in   [DATA_WIDTH-1:0] write data
//   wr_be      in   [NUM_BYTES-1:0]  byte enables, bit k covers byte k
//   rd_en      in   read request
//   rd_addr    in   [ADDR_WIDTH-1:0] read word address
//   rd_data    out  [DATA_WIDTH-1:0] registered read data
//   rd_valid   out  rd_data was loaded by a read accepted on the last edge
//   addr_err   out  one-cycle pulse for an out-of-range accepted request
//   init_busy  out  memory clear in progress
// ---------------------------------------------------------------------------
module sram_sync_param #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 5,
  parameter  int DEPTH      = 24,
  localparam int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  init_busy
);

  // FSM encoding
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // The depth is held one bit wider than an address, so that
  // DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

  // Replace each byte of old_word whose enable is set with the matching
  // byte of new_word.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (be[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [0:0]            state_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic                  init_busy_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;
  logic                  addr_err_r;

  logic                  in_run_s;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  wr_accept_s;
  logic                  wr_oor_s;
  logic                  rd_accept_s;
  logic                  rd_oor_s;
  logic [DATA_WIDTH-1:0] wr_old_s;
  logic [DATA_WIDTH-1:0] wr_merged_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Classify the requests that are presented for the coming edge.
  always_comb begin
    in_run_s      = (state_r == ST_RUN);
    wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
    wr_accept_s   = in_run_s & wr_en & wr_in_range_s;
    wr_oor_s      = in_run_s & wr_en & ~wr_in_range_s;
    rd_accept_s   = in_run_s & rd_en;
    rd_oor_s      = in_run_s & rd_en & ~rd_in_range_s;
  end

  // Form the byte-merged word for an in-range write.
  always_comb begin
    wr_old_s    = ZERO_WORD;
    wr_merged_s = ZERO_WORD;
    if (wr_in_range_s) begin
      wr_old_s    = mem_r[wr_addr];
      wr_merged_s = byte_merge(wr_old_s, wr_data, wr_be);
    end else begin
      wr_old_s    = ZERO_WORD;
      wr_merged_s = ZERO_WORD;
    end
  end

  // Select the array write port: the clear walk owns the port during INIT.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {ADDR_WIDTH{1'b0}};
    mem_wdata_s = ZERO_WORD;
    if (state_r == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_r;
      mem_wdata_s = ZERO_WORD;
    end else if (wr_accept_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_merged_s;
    end else begin
      mem_we_s    = 1'b0;
      mem_waddr_s = {ADDR_WIDTH{1'b0}};
      mem_wdata_s = ZERO_WORD;
    end
  end

  // Choose the read result. A same-word write forwards its merged value
  // (write-first). An out-of-range read returns zero.
  always_comb begin
    rd_word_s = ZERO_WORD;
    if (!rd_in_range_s) begin
      rd_word_s = ZERO_WORD;
    end else if (wr_accept_s && (wr_addr == rd_addr)) begin
      rd_word_s = wr_merged_s;
    end else begin
      rd_word_s = mem_r[rd_addr];
    end
  end

  // Storage array. It has no reset because INIT clears every word. While
  // rst_n is low, the array only rewrites zero into word 0.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // INIT/RUN sequencing and the clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      clr_cnt_r   <= {ADDR_WIDTH{1'b0}};
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_r     <= ST_RUN;
            clr_cnt_r   <= {ADDR_WIDTH{1'b0}};
            init_busy_r <= 1'b0;
          end else begin
            clr_cnt_r   <= clr_cnt_r + ADDR_ONE;
            init_busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r     <= ST_RUN;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_INIT;
          clr_cnt_r   <= {ADDR_WIDTH{1'b0}};
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Registered read response and address-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= ZERO_WORD;
      rd_valid_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_accept_s;
      addr_err_r <= wr_oor_s | rd_oor_s;
      if (rd_accept_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign addr_err  = addr_err_r;
  assign init_busy = init_busy_r;

endmodule
